// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the vector MAC (mac_vec_acc).
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_state_e;

  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                        ovf;
    logic signed [SAT_MAX_W-1:0] val;
  } sat_res_t;

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

  // Signed add clamped to the range of a w-bit two's-complement value (w <= SAT_MAX_W).
  function automatic sat_res_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                       input logic signed [SAT_MAX_W-1:0] b,
                                       input int w);
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sat_res_t r;
    sum   = $signed({a[SAT_MAX_W-1], a}) + $signed({b[SAT_MAX_W-1], b});
    hi    = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo    = -(65'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.val = sum[SAT_MAX_W-1:0];
    if (sum > hi) begin
      r.val = hi[SAT_MAX_W-1:0];
      r.ovf = 1'b1;
    end else if (sum < lo) begin
      r.val = lo[SAT_MAX_W-1:0];
      r.ovf = 1'b1;
    end else begin
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// First pipeline stage of the vector MAC: registers the lane products of an
// accepted beat and reduces them to a single sign-extended lane sum.
module mac_lane_sum
  import mac_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 2 * N + 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  input  logic [LANES*N-1:0]      value_i,
  input  logic [LANES*N-1:0]      mult_i,
  output logic                    sum_valid_o,
  output logic signed [ACC_W-1:0] sum_o
);

  localparam int PROD_W = prod_width(N);

  logic signed [PROD_W-1:0] prod_q [LANES];
  logic                     valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= {PROD_W{1'b0}};
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        for (int k = 0; k < LANES; k++) begin
          prod_q[k] <= PROD_W'($signed(value_i[k*N +: N])) * PROD_W'($signed(mult_i[k*N +: N]));
        end
      end
    end
  end

  always_comb begin
    sum_o = {ACC_W{1'b0}};
    for (int k = 0; k < LANES; k++) sum_o = sum_o + ACC_W'(prod_q[k]);
  end

  assign sum_valid_o = valid_q;

endmodule

// File: rtl/mac_vec_acc.sv
// Vectorised multi-lane MAC: accumulates len+1 beats of lane dot products onto a bias.
// Define MAC_SAT_EN for saturating accumulation with a sticky ovf_o flag.
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int N     = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 2 * N + 8,
  parameter int LEN_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [ACC_W-1:0]   bias_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [LANES*N-1:0] value_i,
  input  logic [LANES*N-1:0] mult_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ACC_W-1:0]   mac_o,
  output logic               ovf_o,
  output logic               busy_o
);

  mac_state_e              state_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum_s;
  logic                    sum_valid_s;
  logic                    beat_s;
  logic                    out_valid_q;
  logic                    ovf_q;
  logic                    ovf_d;

  assign in_ready_o  = (state_q == IDLE) || (state_q == ACCUM);
  assign beat_s      = in_valid_i && in_ready_o && !clr_i;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign mac_o       = acc_q;
  assign ovf_o       = ovf_q;

  mac_lane_sum #(
    .N     (N),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_lane_sum (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (clr_i),
    .in_valid_i  (beat_s),
    .value_i     (value_i),
    .mult_i      (mult_i),
    .sum_valid_o (sum_valid_s),
    .sum_o       (sum_s)
  );

`ifdef MAC_SAT_EN
  sat_res_t sat_s;

  always_comb begin
    sat_s = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(sum_s), ACC_W);
    acc_d = sat_s.val[ACC_W-1:0];
    ovf_d = ovf_q | sat_s.ovf;
  end
`else
  always_comb begin
    acc_d = acc_q + sum_s;
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      len_q       <= {LEN_W{1'b0}};
      cnt_q       <= {LEN_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      cnt_q       <= {LEN_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (sum_valid_s) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
      case (state_q)
        IDLE: begin
          if (beat_s) begin
            len_q   <= len_i;
            cnt_q   <= LEN_W'(1'b1);
            acc_q   <= bias_i;
            state_q <= (len_i == {LEN_W{1'b0}}) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (beat_s) begin
            cnt_q <= cnt_q + LEN_W'(1'b1);
            if (cnt_q == len_q) state_q <= DRAIN;
          end
        end
        // The last lane sum is added this cycle, so the result is final at the next edge.
        DRAIN: begin
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= {LEN_W{1'b0}};
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Self-checking bench for mac_vec_acc: directed scenarios plus random jobs against a dot-product model.
module tb_mac_vec_acc;

  localparam int N     = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 20;
  localparam int LEN_W = 10;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  logic               clk_i = 1'b0;
  logic               rst_i, clr_i, in_valid_i, out_ready_i;
  logic [LEN_W-1:0]   len_i;
  logic [ACC_W-1:0]   bias_i;
  logic [LANES*N-1:0] value_i, mult_i;
  logic               in_ready_o, out_valid_o, ovf_o, busy_o;
  logic [ACC_W-1:0]   mac_o;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint model_acc;
  bit     model_ovf;

  mac_vec_acc #(.N(N), .LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .len_i(len_i), .bias_i(bias_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .value_i(value_i), .mult_i(mult_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .mac_o(mac_o), .ovf_o(ovf_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic longint lane_dot(input logic [LANES*N-1:0] v, input logic [LANES*N-1:0] m);
    longint s = 0;
    for (int k = 0; k < LANES; k++) begin
      logic signed [N-1:0] a;
      logic signed [N-1:0] b;
      a = v[k*N +: N];
      b = m[k*N +: N];
      s += longint'(a) * longint'(b);
    end
    return s;
  endfunction

  function automatic longint wrap_acc(input longint x);
    longint r;
    r = x & ((longint'(1) <<< ACC_W) - 1);
    if (r > ACC_MAX) r -= (longint'(1) <<< ACC_W);
    return r;
  endfunction

  task automatic model_beat(input logic [LANES*N-1:0] v, input logic [LANES*N-1:0] m);
    model_acc += lane_dot(v, m);
`ifdef MAC_SAT_EN
    if (model_acc > ACC_MAX) begin model_acc = ACC_MAX; model_ovf = 1'b1; end
    if (model_acc < ACC_MIN) begin model_acc = ACC_MIN; model_ovf = 1'b1; end
`endif
  endtask

  function automatic longint exp_mac();
`ifdef MAC_SAT_EN
    return model_acc;
`else
    return wrap_acc(model_acc);
`endif
  endfunction

  function automatic logic [LANES*N-1:0] rand_vec();
    logic [LANES*N-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*N +: N] = N'($urandom);
    return v;
  endfunction

  // Idle cycles carrying garbage that must not reach the accumulator.
  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid_i = 1'b0;
      value_i    = rand_vec();
      mult_i     = rand_vec();
      len_i      = LEN_W'($urandom);
      bias_i     = ACC_W'($urandom);
      tick();
    end
  endtask

  task automatic send_beat(input logic [LANES*N-1:0] v, input logic [LANES*N-1:0] m,
                           input logic [LEN_W-1:0] len, input logic [ACC_W-1:0] bias, input bit first);
    check("in_ready_beat", in_ready_o, 1);
    in_valid_i = 1'b1;
    value_i    = v;
    mult_i     = m;
    len_i      = len;
    bias_i     = bias;
    if (first) begin
      model_acc = longint'($signed(bias));
      model_ovf = 1'b0;
    end
    model_beat(v, m);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int lat = 1;
    check({tag, "_in_ready_drain"}, in_ready_o, 0);
    while (!out_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_mac"}, $signed(mac_o), exp_mac());
`ifdef MAC_SAT_EN
    check({tag, "_ovf"}, ovf_o, model_ovf);
`else
    check({tag, "_ovf"}, ovf_o, 0);
`endif
    check({tag, "_in_ready_out"}, in_ready_o, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_valid_after_hs"}, out_valid_o, 0);
    check({tag, "_busy_after_hs"}, busy_o, 0);
    check({tag, "_ready_after_hs"}, in_ready_o, 1);
    check({tag, "_ovf_after_hs"}, ovf_o, 0);
  endtask

  task automatic random_job(input string tag, input int len);
    logic [ACC_W-1:0] bias;
    bias = ACC_W'(int'($urandom_range(10000)) - 5000);
    for (int b = 0; b <= len; b++) begin
      send_beat(rand_vec(), rand_vec(), LEN_W'(len), bias, b == 0);
      if (b != len) gap_cycles(int'($urandom_range(2)));
    end
    wait_result(tag);
    gap_cycles(int'($urandom_range(3)));
    handshake(tag);
  endtask

  initial begin
    logic [LANES*N-1:0] v1, m1, ones, negs, big, v4, m4;
    logic [63:0]        held;
    v1   = {8'd4, 8'd3, 8'd2, 8'd1};
    m1   = {8'd8, 8'd7, 8'd6, 8'd5};
    ones = {8'd1, 8'd1, 8'd1, 8'd1};
    negs = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    big  = {8'h80, 8'h80, 8'h80, 8'h80};
    v4   = {8'd0, 8'd0, 8'd0, 8'd1};
    m4   = {8'd0, 8'd0, 8'd0, 8'd3};

    rst_i = 1'b1; clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    len_i = '0; bias_i = '0; value_i = '0; mult_i = '0;
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_mac", mac_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Scenario 1: single-beat job.
    send_beat(v1, m1, 10'd0, 20'd0, 1'b1);
    wait_result("s1");
    check("s1_const", $signed(mac_o), 70);
    handshake("s1");

    // Scenario 2: three beats with two-cycle gaps onto a bias.
    for (int b = 0; b < 3; b++) begin
      send_beat(ones, negs, 10'd2, 20'd10, b == 0);
      if (b != 2) gap_cycles(2);
    end
    wait_result("s2");
    check("s2_const", $signed(mac_o), -2);
    handshake("s2");

    // Scenario 3: result held under backpressure while beats are offered.
    send_beat(rand_vec(), rand_vec(), 10'd1, 20'd100, 1'b1);
    send_beat(rand_vec(), rand_vec(), 10'd1, 20'd100, 1'b0);
    wait_result("s3");
    held = 64'($signed(mac_o));
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      value_i    = rand_vec();
      mult_i     = rand_vec();
      tick();
      check("s3_hold_valid", out_valid_o, 1);
      check("s3_hold_mac", $signed(mac_o), $signed(held));
      check("s3_hold_ready", in_ready_o, 0);
    end
    in_valid_i = 1'b0;
    handshake("s3");

    // Scenario 4: abort mid-job with a beat offered in the clear cycle.
    send_beat(rand_vec(), rand_vec(), 10'd5, 20'd777, 1'b1);
    send_beat(rand_vec(), rand_vec(), 10'd5, 20'd777, 1'b0);
    clr_i      = 1'b1;
    in_valid_i = 1'b1;
    value_i    = rand_vec();
    tick();
    clr_i      = 1'b0;
    in_valid_i = 1'b0;
    check("s4_busy_clr", busy_o, 0);
    check("s4_ready_clr", in_ready_o, 1);
    check("s4_valid_clr", out_valid_o, 0);
    gap_cycles(2);
    send_beat(v4, m4, 10'd0, 20'd0, 1'b1);
    wait_result("s4");
    check("s4_const", $signed(mac_o), 3);
    handshake("s4");

    // Scenario 5: accumulation past the accumulator range.
    for (int b = 0; b < 9; b++) send_beat(big, big, 10'd8, 20'd0, b == 0);
    wait_result("s5");
`ifdef MAC_SAT_EN
    check("s5_const", $signed(mac_o), 524287);
    check("s5_ovf_const", ovf_o, 1);
`else
    check("s5_const", $signed(mac_o), -458752);
    check("s5_ovf_const", ovf_o, 0);
`endif
    handshake("s5");

    // Scenario 6: asynchronous reset in the middle of a job.
    send_beat(rand_vec(), rand_vec(), 10'd5, 20'd55, 1'b1);
    send_beat(rand_vec(), rand_vec(), 10'd5, 20'd55, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    check("s6_valid", out_valid_o, 0);
    check("s6_mac", mac_o, 0);
    check("s6_ovf", ovf_o, 0);
    check("s6_busy", busy_o, 0);
    check("s6_ready", in_ready_o, 1);
    tick();
    rst_i = 1'b0;
    tick();
    send_beat(v1, m1, 10'd0, 20'd0, 1'b1);
    wait_result("s6_after");
    check("s6_after_const", $signed(mac_o), 70);
    handshake("s6_after");

    // Random jobs of varying length.
    for (int j = 0; j < 8; j++) random_job("rnd", int'($urandom_range(6)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_vec_acc.md
Name: mac_vec_acc

Overview:
Vectorised multi-lane MAC for the dense/conv layers.
- Each accepted beat delivers LANES signed operand pairs; the block multiplies them, sums the lanes, and accumulates over a programmable number of beats onto a bias.
- Emits one dot-product result per job over a valid/ready handshake.
- Sits between the weight/activation streamers and the activation/requantise stage.

Parameters:
N, 16, signed operand width per lane
LANES, 4, operand pairs per beat (>=1)
ACC_W, 2*N+8, accumulator/result width (>= 2*N+$clog2(LANES))
LEN_W, 10, width of beat-count field

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
clr_i  in  1  synchronous abort/flush
len_i  in  LEN_W  beats per job minus 1; sampled on the first beat of a job
bias_i  in  ACC_W  signed initial accumulator value; sampled on the first beat
in_valid_i  in  1  beat valid
in_ready_o  out  1  beat ready
value_i  in  LANES*N  packed signed lanes; lane k = bits [k*N +: N]
mult_i  in  LANES*N  packed signed lanes
out_valid_o  out  1  result valid
out_ready_i  in  1  result accepted
mac_o  out  ACC_W  signed result
ovf_o  out  1  sticky overflow for the current result
busy_o  out  1  job in progress (state != IDLE)

Behaviour:
- Reset is asynchronous, active-high, on rst_i; clock is clk_i.
- Reset values: state IDLE, out_valid_o=0, mac_o=0, ovf_o=0, busy_o=0, pipeline valids=0, accumulator=0, beat counter=0. in_ready_o=1 out of reset (decoded from IDLE).
- Beat accepted when in_valid_i && in_ready_o.
- Arithmetic: all signed.
  - Lane product is 2N bits.
  - Lane sum is sign-extended to ACC_W.
  - acc <= acc + lane_sum.
  - Without the optional feature, wrap-around is modulo 2^ACC_W.
- Pipeline:
  - S1 registers the LANES products of an accepted beat.
  - S2 adds the lane sum into the accumulator.
  - First beat: accumulator is loaded with bias_i on acceptance, before its S2 add.
- Latency: last beat accepted at cycle t -> out_valid_o=1 at t+2.
- FSM states:
  - IDLE: in_ready_o=1. First beat captures len_i and bias_i. If len_i==0 go to DRAIN, else ACCUM.
  - ACCUM: in_ready_o=1. Counter increments per accepted beat. Gaps in in_valid_i are allowed and add nothing. Beat number len_i+1 -> DRAIN.
  - DRAIN: in_ready_o=0. Waits until the pipeline is empty, then sets out_valid_o and goes to OUT.
  - OUT: in_ready_o=0. mac_o/ovf_o held stable while out_valid_o && !out_ready_i. On handshake: out_valid_o=0, ovf_o cleared, next state IDLE. There is no overlap between jobs.
- clr_i: next cycle forces IDLE, clears pipeline valids, out_valid_o, ovf_o and the counter. An in-flight beat is discarded. clr_i has priority over all handshakes in the same cycle.
- Async reset mid-job: same effect as clr_i, applied immediately; mac_o=0.
- Changes to len_i/bias_i after the first beat are ignored for the current job.
- Without the optional feature, ovf_o is tied to 0.

Optional Feature:
MAC_SAT_EN
- Defined: each S2 add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. ovf_o is set (sticky until the result handshake or clr_i) whenever saturation occurs.
- Undefined: wrap-around arithmetic; ovf_o constant 0; no saturation logic synthesised.

Decomposition:
- Package mac_pkg:
  - state enum (IDLE, ACCUM, DRAIN, OUT)
  - localparam PROD_W=2*N
  - function for signed saturating add, parametrised by width
- Sub-module mac_lane_sum: registered LANES multipliers plus combinational adder tree. Outputs lane sum with a valid bit; this is S1 plus the tree.
- The top level holds the FSM, counter, accumulator and handshake.

Test Plan:
All scenarios use N=8, LANES=4, ACC_W=20.
1. len=0, bias=0, value={1,2,3,4}, mult={5,6,7,8} -> out_valid_o at t+2, mac_o=70, ovf_o=0.
2. len=2, bias=10, all lanes value=1/mult=-1, 2-cycle in_valid_i gaps between beats -> mac_o=-2; in_ready_o=0 from DRAIN until the handshake.
3. Result held with out_ready_i=0 for 5 cycles -> mac_o/out_valid_o stable, in_ready_o=0, beats ignored; handshake -> IDLE next cycle.
4. clr_i asserted after beat 2 of a len=5 job; new job len=0, value={1,0,0,0}, mult={3,0,0,0} -> mac_o=3 only, no residue.
5. len=8, bias=0, all lanes -128*-128, giving 9*65536=589824:
   - MAC_SAT_EN defined -> mac_o=524287, ovf_o=1.
   - Undefined -> mac_o=-458752, ovf_o=0.
6. rst_i pulsed mid-ACCUM -> all outputs 0 and in_ready_o=1 immediately; following job from scenario 1 yields 70.
